// File: rtl/duty_ramp_multi.sv
// Multi-channel duty ramp buffer: each channel walks its duty toward a latched target
// by a programmable step every programmable number of clocks. Optional macro: DUTY_CLAMP_EN.
module duty_ramp_multi #(
    parameter int CH        = 4,
    parameter int DW        = 20,
    parameter int GW        = 12,
    parameter int SW        = 8,
    parameter int INIT_DUTY = 0,
    parameter int DUTY_MIN  = 25_000,
    parameter int DUTY_MAX  = 125_000,
    localparam int CW       = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           cfg_valid,
    output logic           cfg_ready,
    input  logic [CW-1:0]  cfg_ch,
    input  logic [DW-1:0]  cfg_need,
    input  logic [GW-1:0]  cfg_gap,
    input  logic [SW-1:0]  cfg_step,
    output logic [CH*DW-1:0] duty_out,
    output logic [CH-1:0]  at_target,
    output logic           busy
);

`ifdef DUTY_CLAMP_EN
    localparam bit CLAMP_EN = 1'b1;
`else
    localparam bit CLAMP_EN = 1'b0;
`endif

    function automatic logic [DW-1:0] clamp_need(input logic [DW-1:0] v);
        if (CLAMP_EN && (v < DW'(DUTY_MIN))) begin
            clamp_need = DW'(DUTY_MIN);
        end else if (CLAMP_EN && (v > DW'(DUTY_MAX))) begin
            clamp_need = DW'(DUTY_MAX);
        end else begin
            clamp_need = v;
        end
    endfunction

    localparam logic [DW-1:0] INIT_S = clamp_need(DW'(INIT_DUTY));

    logic cfg_ready_r;

    // config port is ready every cycle except the reset cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_ready_r <= 1'b0;
        end else begin
            cfg_ready_r <= 1'b1;
        end
    end

    assign cfg_ready = cfg_ready_r;
    assign busy      = ~&at_target;

    for (genvar i = 0; i < CH; i++) begin : g_ch
        logic [DW-1:0] duty_r;
        logic [DW-1:0] need_r;
        logic [GW-1:0] gap_r;
        logic [GW-1:0] count_r;
        logic [SW-1:0] step_r;
        logic [DW-1:0] duty_nxt_s;
        logic [GW-1:0] count_nxt_s;
        logic [DW:0]   step_s;
        logic [DW:0]   diff_s;
        logic          wr_s;
        logic          step_evt_s;

        // gap counter and clamped step toward need, evaluated in DW+1 bits
        always_comb begin
            wr_s        = cfg_valid && cfg_ready_r && (cfg_ch == CW'(i));
            step_s      = (DW+1)'(step_r);
            diff_s      = {(DW+1){1'b0}};
            step_evt_s  = 1'b0;
            count_nxt_s = count_r;
            duty_nxt_s  = duty_r;
            if (duty_r == need_r) begin
                count_nxt_s = {GW{1'b0}};
            end else if (count_r == (gap_r - GW'(1'b1))) begin
                count_nxt_s = {GW{1'b0}};
                step_evt_s  = 1'b1;
            end else begin
                count_nxt_s = count_r + GW'(1'b1);
            end
            if (step_evt_s && (duty_r < need_r)) begin
                diff_s     = {1'b0, need_r} - {1'b0, duty_r};
                duty_nxt_s = (step_s >= diff_s) ? need_r : DW'({1'b0, duty_r} + step_s);
            end else if (step_evt_s) begin
                diff_s     = {1'b0, duty_r} - {1'b0, need_r};
                duty_nxt_s = (step_s >= diff_s) ? need_r : DW'({1'b0, duty_r} - step_s);
            end else begin
                diff_s     = {(DW+1){1'b0}};
            end
        end

        // a write wins over a same-cycle step event and restarts the gap count
        always_ff @(posedge clk) begin
            if (rst) begin
                duty_r  <= INIT_S;
                need_r  <= INIT_S;
                gap_r   <= GW'(1'b1);
                step_r  <= SW'(1'b1);
                count_r <= {GW{1'b0}};
            end else if (wr_s) begin
                need_r  <= clamp_need(cfg_need);
                gap_r   <= (cfg_gap == {GW{1'b0}}) ? GW'(1'b1) : cfg_gap;
                step_r  <= (cfg_step == {SW{1'b0}}) ? SW'(1'b1) : cfg_step;
                count_r <= {GW{1'b0}};
            end else begin
                duty_r  <= duty_nxt_s;
                count_r <= count_nxt_s;
            end
        end

        assign duty_out[i*DW +: DW] = duty_r;
        assign at_target[i]         = (duty_r == need_r);
    end

endmodule

// File: tb/tb_duty_ramp_multi.sv
// Directed self-checking bench for duty_ramp_multi (five channels so that an
// out-of-range channel index is representable on the 3-bit cfg_ch port).
module tb_duty_ramp_multi;
    localparam int CH = 5;
    localparam int DW = 20;
    localparam int GW = 12;
    localparam int SW = 8;
`ifdef DUTY_CLAMP_EN
    localparam int INIT_EXP = 25_000;
    localparam int HI_EXP   = 125_000;
    localparam int LO_EXP   = 25_000;
`else
    localparam int INIT_EXP = 0;
    localparam int HI_EXP   = 200_000;
    localparam int LO_EXP   = 10;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            cfg_valid;
    logic            cfg_ready;
    logic [2:0]      cfg_ch;
    logic [DW-1:0]   cfg_need;
    logic [GW-1:0]   cfg_gap;
    logic [SW-1:0]   cfg_step;
    logic [CH*DW-1:0] duty_out;
    logic [CH-1:0]   at_target;
    logic            busy;

    int checks   = 0;
    int failures = 0;

    duty_ramp_multi #(.CH(CH), .DW(DW), .GW(GW), .SW(SW), .INIT_DUTY(0)) dut (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_ch(cfg_ch), .cfg_need(cfg_need), .cfg_gap(cfg_gap), .cfg_step(cfg_step),
        .duty_out(duty_out), .at_target(at_target), .busy(busy)
    );

    always #10 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] duty_of(input int ch);
        return 32'(duty_out[ch*DW +: DW]);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input int ch, input int need, input int gap, input int step);
        cfg_valid = 1'b1;
        cfg_ch    = 3'(ch);
        cfg_need  = DW'(need);
        cfg_gap   = GW'(gap);
        cfg_step  = SW'(step);
    endtask

    task automatic wr(input int ch, input int need, input int gap, input int step);
        set_cfg(ch, need, gap, step);
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic wait_tgt(input int ch, input int bound);
        int n = 0;
        while (!at_target[ch] && n < bound) begin
            tick();
            n++;
        end
        check_eq("wait_at_target", 32'(at_target[ch]), 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        cfg_valid = 1'b0;
        cfg_ch = 3'd0;
        cfg_need = '0;
        cfg_gap = '0;
        cfg_step = '0;
        repeat (3) tick();
        check_eq("rst_ready_low", 32'(cfg_ready), 32'd0);
        rst = 1'b0;
        tick();
        check_eq("rst_ready", 32'(cfg_ready), 32'd1);
        check_eq("rst_at_target", 32'(at_target), 32'h1F);
        check_eq("rst_busy", 32'(busy), 32'd0);
        for (int c = 0; c < CH; c++) check_eq("rst_duty", duty_of(c), 32'(INIT_EXP));

`ifndef DUTY_CLAMP_EN
        // rising ramp: 0 -> 100 in steps of 10 every 4 clocks
        wr(0, 100, 4, 10);
        check_eq("rise_busy", 32'(busy), 32'd1);
        for (int k = 1; k <= 10; k++) begin
            repeat (3) tick();
            check_eq("rise_hold", duty_of(0), 32'(10 * (k - 1)));
            tick();
            check_eq("rise_step", duty_of(0), 32'(10 * k));
            check_eq("rise_at_target", 32'(at_target[0]), (k == 10) ? 32'd1 : 32'd0);
        end
        for (int c = 1; c < CH; c++) check_eq("rise_others", duty_of(c), 32'd0);
        check_eq("rise_busy_done", 32'(busy), 32'd0);

        // falling ramp without overshoot: 100 -> 90, 80, 75
        wr(1, 100, 1, 255);
        tick();
        check_eq("fall_preload", duty_of(1), 32'd100);
        wr(1, 75, 1, 10);
        check_eq("fall_accept", duty_of(1), 32'd100);
        tick(); check_eq("fall_90", duty_of(1), 32'd90);
        tick(); check_eq("fall_80", duty_of(1), 32'd80);
        tick(); check_eq("fall_75", duty_of(1), 32'd75);
        tick(); check_eq("fall_hold", duty_of(1), 32'd75);
        check_eq("fall_at_target", 32'(at_target[1]), 32'd1);

        // retarget on the exact cycle a step is due: step dropped, ramp reverses
        wr(2, 1000, 2, 1);
        repeat (14) tick();
        check_eq("coll_pre", duty_of(2), 32'd7);
        tick();
        check_eq("coll_mid", duty_of(2), 32'd7);
        wr(2, 5, 2, 1);
        check_eq("coll_dropped", duty_of(2), 32'd7);
        tick(); check_eq("coll_gap", duty_of(2), 32'd7);
        tick(); check_eq("coll_down6", duty_of(2), 32'd6);
        repeat (2) tick();
        check_eq("coll_down5", duty_of(2), 32'd5);
        check_eq("coll_at_target", 32'(at_target[2]), 32'd1);
        repeat (2) tick();
        check_eq("coll_hold", duty_of(2), 32'd5);

        // out-of-range channel indices are accepted and ignored
        set_cfg(5, 999, 1, 1);
        tick();
        set_cfg(7, 999, 1, 1);
        tick();
        cfg_valid = 1'b0;
        repeat (2) tick();
        check_eq("oor_at_target", 32'(at_target), 32'h1F);
        check_eq("oor_ch0", duty_of(0), 32'd100);
        check_eq("oor_ch1", duty_of(1), 32'd75);
        check_eq("oor_ch3", duty_of(3), 32'd0);
        check_eq("oor_ch4", duty_of(4), 32'd0);

        // back-to-back writes to ch3 then ch0
        set_cfg(3, 3, 1, 1);
        tick();
        set_cfg(0, 98, 1, 1);
        tick();
        cfg_valid = 1'b0;
        check_eq("b2b_ch3_a", duty_of(3), 32'd1);
        check_eq("b2b_ch0_a", duty_of(0), 32'd100);
        tick();
        check_eq("b2b_ch3_b", duty_of(3), 32'd2);
        check_eq("b2b_ch0_b", duty_of(0), 32'd99);
        tick();
        check_eq("b2b_ch3_c", duty_of(3), 32'd3);
        check_eq("b2b_ch0_c", duty_of(0), 32'd98);
        check_eq("b2b_ch2", duty_of(2), 32'd5);
        check_eq("b2b_at_target", 32'(at_target), 32'h1F);
`endif

        // large targets: clamped to the servo range only when the clamp is built in
        wr(4, 200_000, 1, 255);
        check_eq("clamp_busy", 32'(busy), 32'd1);
        wait_tgt(4, 2000);
        check_eq("clamp_hi", duty_of(4), 32'(HI_EXP));
        wr(4, 10, 1, 255);
        wait_tgt(4, 2000);
        check_eq("clamp_lo", duty_of(4), 32'(LO_EXP));
        check_eq("clamp_busy_done", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
